// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit : iterative RV32M multiply/divide unit for the EX stage
// Revision: 1.0
// ============================================================================
module ex_muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] result
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [2:0]  op;
   logic [31:0] opa, opb;     // multiplicand/dividend and multiplier/divisor magnitudes
   logic        neg_res;
   logic [4:0]  cnt;
   logic [63:0] acc;

   logic        a_signed, b_signed, a_neg, b_neg, neg_in;
   logic [31:0] a_mag, b_mag;
   logic        div_zero, div_ovf, special, accept;
   logic [31:0] special_val;

   assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
   assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
   assign a_neg    = a_signed & rs1_val[31];
   assign b_neg    = b_signed & rs2_val[31];
   assign a_mag    = a_neg ? (32'd0 - rs1_val) : rs1_val;
   assign b_mag    = b_neg ? (32'd0 - rs2_val) : rs2_val;
   // Remainder follows the dividend sign; everything else is the sign product.
   assign neg_in   = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);

   assign div_zero = funct3[2] && (rs2_val == 32'd0);
   assign div_ovf  = funct3[2] && !funct3[0] &&
                     (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
   assign special  = div_zero || div_ovf;
   always_comb begin
      special_val = 32'd0;
      if (div_zero)
         special_val = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
      else
         special_val = funct3[1] ? 32'd0 : 32'h8000_0000;
   end

   assign accept = (state == IDLE) && start && !flush;

   // One shift-add step and one restoring-subtract step per cycle.
   logic [63:0] mul_nxt, mul_fix, acc_nxt;
   logic [32:0] div_sh, div_diff;
   logic [63:0] div_nxt;
   logic [31:0] div_sel, div_fix, res_calc;

   assign mul_nxt  = acc + (opb[0] ? ({32'd0, opa} << cnt) : 64'd0);
   assign mul_fix  = neg_res ? (64'd0 - mul_nxt) : mul_nxt;
   assign div_sh   = {acc[63:32], acc[31]};
   assign div_diff = div_sh - {1'b0, opb};
   assign div_nxt  = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0], acc[30:0], 1'b1};
   assign acc_nxt  = op[2] ? div_nxt : mul_nxt;
   assign div_sel  = op[1] ? div_nxt[63:32] : div_nxt[31:0];
   assign div_fix  = neg_res ? (32'd0 - div_sel) : div_sel;
   assign res_calc = op[2] ? div_fix : ((op == 3'b000) ? mul_fix[31:0] : mul_fix[63:32]);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (start) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == 5'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
         stall = !rst && (((state == IDLE) && start) || (state == CALC));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done    <= 1'b0;
         result  <= 32'd0;
         cnt     <= 5'd0;
         acc     <= 64'd0;
         op      <= 3'd0;
         opa     <= 32'd0;
         opb     <= 32'd0;
         neg_res <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            op      <= funct3;
            opa     <= a_mag;
            opb     <= b_mag;
            neg_res <= neg_in;
            cnt     <= 5'd0;
            acc     <= funct3[2] ? {32'd0, a_mag} : 64'd0;
            if (special) begin
               result <= special_val;
               done   <= 1'b1;
            end
         end else if ((state == CALC) && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt + 5'd1;
            if (!op[2]) opb <= opb >> 1;
            if (cnt == 5'd31) begin
               result <= res_calc;
               done   <= 1'b1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv_unit : directed self-checking bench for ex_muldiv_unit
// Revision: 1.0
// ============================================================================
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic        stall, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .flush   (flush),
      .stall   (stall),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents one operation, then watches for done; hold keeps start and operands
   // asserted so the next call is accepted in the IDLE cycle right after DONE.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit hold);
      int  k;
      int  stalls;
      bit  seen;
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
      #1 check({tag, "_accept_stall"}, {31'd0, stall}, 32'd1);
      stalls = stall ? 1 : 0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (!hold) begin
            start = 1'b0; rs1_val = $urandom; rs2_val = $urandom;
         end
         #1;
         if (done) seen = 1'b1;
         else if (stall) stalls++;
      end
      check({tag, "_latency"}, k, lat);
      check({tag, "_result"}, result, exp);
      check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_stall_cycles"}, stalls, lat);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0;
      rs1_val = 32'd7; rs2_val = 32'd9;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      start = 1'b0; rst = 1'b0;

      run_op("mul_7xm3",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
      run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
      run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
      run_op("mulhsu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
      run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
      run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
      run_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'h0000_000E, 33, 0);
      run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'h0000_0002, 33, 0);
      run_op("div_by0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
      run_op("divu_by0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
      run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
      run_op("remu_by0",   3'b111, 32'd5,         32'd0,         32'h0000_0005, 1, 0);

      // Flush in the 10th CALC cycle.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; rs1_val = 32'h1234; rs2_val = 32'h10;
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      #1 check("flush_stall_now", {31'd0, stall}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_stall_after", {31'd0, stall}, 32'd0);
      check("flush_result_kept", result, 32'h0000_0005);
      repeat (3) @(negedge clk);
      #1 check("flush_no_late_done", {31'd0, done}, 32'd0);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'h0000_000C, 33, 0);

      // Reset pulsed mid-CALC.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1 check("midrst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_idle_stall", {31'd0, stall}, 32'd0);
      run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 33, 0);

      // start held across DONE: second op accepted in the following IDLE cycle.
      run_op("b2b_first",  3'b000, 32'd6, 32'd5, 32'h0000_001E, 33, 1);
      run_op("b2b_second", 3'b000, 32'd6, 32'd5, 32'h0000_001E, 33, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
